// File: rtl/xbar_mult_sequencer.sv
// xbar_mult_sequencer
// Control-side initiator for the multiplier -> XBar -> multiplier -> mux datapath.
// One job consists of a routing word followed by an operand stream. The block
// fills buffer0 and then buffer1 of the input bank, starts that bank and waits
// for it to finish. It then routes the products through the XBar into both
// buffers of the output bank, starts the output bank, waits again, and finally
// drains every output product through the mux as a valid/ready result stream.
//
// Ports
//   i_clk, i_rst_n                 clock (rising edge) and asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready        job request handshake, with i_cmd_addr (the XBar routing word)
//   i_load_valid/o_load_ready      operand stream handshake, with i_load_data
//   o_data_in                      operand word to the input bank (combinational copy of i_load_data)
//   o_buffer_rd_in/_rd_out         buffer control per multiplier: 0 = fill, 1 = hold
//   o_buffer_select                selects buffer0 or buffer1
//   o_mstart_in/_out               one-cycle start pulses for the input and output banks
//   i_mready_in/_out               done flags from the input and output banks
//   o_address_select               XBar routing word
//   o_output_select, i_mux_data    mux select and the mux data it returns
//   o_res_valid/i_res_ready        result handshake, with o_res_data and o_res_index
//   o_busy                         high whenever the block is not idle
//   o_timeout_err                  sticky wait timeout flag, cleared by the next job
module xbar_mult_sequencer #(
  parameter int IN_PORTS   = 4,
  parameter int OUT_PORTS  = 4,
  parameter int BIT_LENGTH = 32,
  parameter int ADDR_LEN   = 8,
  parameter int SEL_LEN    = 2,
  parameter int LOAD_LEN   = 8,
  parameter int XBAR_LAT   = 1,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_LEN-1:0]   i_cmd_addr,
  input  logic                  i_load_valid,
  output logic                  o_load_ready,
  input  logic [BIT_LENGTH-1:0] i_load_data,
  output logic [BIT_LENGTH-1:0] o_data_in,
  output logic [IN_PORTS-1:0]   o_buffer_rd_in,
  output logic [OUT_PORTS-1:0]  o_buffer_rd_out,
  output logic                  o_buffer_select,
  output logic                  o_mstart_in,
  output logic                  o_mstart_out,
  input  logic [IN_PORTS-1:0]   i_mready_in,
  input  logic [OUT_PORTS-1:0]  i_mready_out,
  output logic [ADDR_LEN-1:0]   o_address_select,
  output logic [SEL_LEN-1:0]    o_output_select,
  input  logic [BIT_LENGTH-1:0] i_mux_data,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [BIT_LENGTH-1:0] o_res_data,
  output logic [SEL_LEN-1:0]    o_res_index,
  output logic                  o_busy,
  output logic                  o_timeout_err
);

  localparam int CNT_W  = $clog2(XBAR_LAT + 2 * LOAD_LEN + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  // Counter values at which something happens, in counter width.
  localparam logic [CNT_W-1:0]   C_LOAD_HALF = CNT_W'(LOAD_LEN - 1);
  localparam logic [CNT_W-1:0]   C_LOAD_END  = CNT_W'(2 * LOAD_LEN - 1);
  localparam logic [CNT_W-1:0]   C_RT_START  = CNT_W'(XBAR_LAT);
  localparam logic [CNT_W-1:0]   C_RT_HALF   = CNT_W'(XBAR_LAT + LOAD_LEN - 1);
  localparam logic [CNT_W-1:0]   C_RT_END    = CNT_W'(XBAR_LAT + 2 * LOAD_LEN - 1);
  localparam logic [WAIT_W-1:0]  C_TO_LAST   = WAIT_W'(TIMEOUT - 1);
  localparam logic [SEL_LEN-1:0] C_LAST_SEL  = SEL_LEN'(OUT_PORTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START_IN, S_WAIT_IN, S_ROUTE, S_START_OUT, S_WAIT_OUT, S_DRAIN
  } state_t;

  state_t                  r_state, w_state_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  logic [WAIT_W-1:0]       r_wait, w_wait_next;
  logic                    r_bsel, w_bsel_next;
  logic [ADDR_LEN-1:0]     r_addr, w_addr_next;
  logic [SEL_LEN-1:0]      r_sel, w_sel_next;
  logic                    r_pend, w_pend_next;   // r_sel points at a word not yet captured
  logic                    r_res_valid, w_res_valid_next;
  logic [BIT_LENGTH-1:0]   r_res_data, w_res_data_next;
  logic [SEL_LEN-1:0]      r_res_index, w_res_index_next;
  logic                    r_terr, w_terr_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_bsel      <= 1'b0;
      r_addr      <= '0;
      r_sel       <= '0;
      r_pend      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_index <= '0;
      r_terr      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_wait      <= w_wait_next;
      r_bsel      <= w_bsel_next;
      r_addr      <= w_addr_next;
      r_sel       <= w_sel_next;
      r_pend      <= w_pend_next;
      r_res_valid <= w_res_valid_next;
      r_res_data  <= w_res_data_next;
      r_res_index <= w_res_index_next;
      r_terr      <= w_terr_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_wait_next      = r_wait;
    w_bsel_next      = r_bsel;
    w_addr_next      = r_addr;
    w_sel_next       = r_sel;
    w_pend_next      = r_pend;
    w_res_valid_next = r_res_valid;
    w_res_data_next  = r_res_data;
    w_res_index_next = r_res_index;
    w_terr_next      = r_terr;
    o_cmd_ready      = 1'b0;
    o_load_ready     = 1'b0;
    o_buffer_rd_in   = '1;
    o_buffer_rd_out  = '1;
    o_mstart_in      = 1'b0;
    o_mstart_out     = 1'b0;

    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_addr_next  = i_cmd_addr;
          w_terr_next  = 1'b0;
          w_cnt_next   = '0;
          w_wait_next  = '0;
          w_bsel_next  = 1'b0;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        o_load_ready = 1'b1;
        if (i_load_valid) begin
          // Buffers only write in cycles where a word is actually transferred.
          o_buffer_rd_in = '0;
          w_cnt_next     = r_cnt + 1'b1;
          if (r_cnt == C_LOAD_HALF) w_bsel_next = 1'b1;
          if (r_cnt == C_LOAD_END) begin
            w_bsel_next  = 1'b0;
            w_cnt_next   = '0;
            w_state_next = S_START_IN;
          end
        end
      end
      S_START_IN: begin
        o_mstart_in  = 1'b1;
        w_wait_next  = '0;
        w_state_next = S_WAIT_IN;
      end
      S_WAIT_IN: begin
        if (&i_mready_in) begin
          w_cnt_next   = '0;
          w_state_next = S_ROUTE;
        end else if (r_wait == C_TO_LAST) begin
          w_terr_next  = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      S_ROUTE: begin
        // The first XBAR_LAT cycles let the XBar settle on the routing word
        // before the output buffers start capturing.
        if (r_cnt >= C_RT_START) o_buffer_rd_out = '0;
        if (r_cnt == C_RT_HALF) w_bsel_next = 1'b1;
        if (r_cnt == C_RT_END) begin
          w_bsel_next  = 1'b0;
          w_cnt_next   = '0;
          w_state_next = S_START_OUT;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_START_OUT: begin
        o_mstart_out = 1'b1;
        w_wait_next  = '0;
        w_state_next = S_WAIT_OUT;
      end
      S_WAIT_OUT: begin
        if (&i_mready_out) begin
          w_sel_next       = '0;
          w_pend_next      = 1'b1;
          w_res_valid_next = 1'b0;
          w_state_next     = S_DRAIN;
        end else if (r_wait == C_TO_LAST) begin
          w_terr_next  = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      S_DRAIN: begin
        // r_sel has been on the mux for at least one cycle whenever r_pend is
        // set, so i_mux_data is settled. The select moves on as soon as its
        // word is captured, which keeps back-to-back results gap-free.
        if (r_pend && (!r_res_valid || i_res_ready)) begin
          w_res_data_next  = i_mux_data;
          w_res_index_next = r_sel;
          w_res_valid_next = 1'b1;
          if (r_sel == C_LAST_SEL) w_pend_next = 1'b0;
          else                     w_sel_next  = r_sel + 1'b1;
        end else if (!r_pend && r_res_valid && i_res_ready) begin
          w_res_valid_next = 1'b0;
          w_state_next     = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_data_in        = i_load_data;
  assign o_buffer_select  = r_bsel;
  assign o_address_select = r_addr;
  assign o_output_select  = r_sel;
  assign o_res_valid      = r_res_valid;
  assign o_res_data       = r_res_data;
  assign o_res_index      = r_res_index;
  assign o_busy           = (r_state != S_IDLE);
  assign o_timeout_err    = r_terr;

endmodule

// File: tb/tb_xbar_mult_sequencer.sv
module tb_xbar_mult_sequencer;
  localparam int IN_PORTS = 4, OUT_PORTS = 4, BIT_LENGTH = 32, ADDR_LEN = 8, SEL_LEN = 2;
  localparam int LOAD_LEN = 8, XBAR_LAT = 1, TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  cmd_valid = 1'b0, load_valid = 1'b0, res_ready = 1'b0;
  logic [ADDR_LEN-1:0]   cmd_addr = '0;
  logic [BIT_LENGTH-1:0] load_data = '0;
  logic [IN_PORTS-1:0]   mready_in = '0;
  logic [OUT_PORTS-1:0]  mready_out = '0;
  logic [BIT_LENGTH-1:0] mux_vals [OUT_PORTS];
  logic [BIT_LENGTH-1:0] mux_data;

  logic                  o_cmd_ready, o_load_ready, o_buffer_select, o_mstart_in, o_mstart_out;
  logic                  o_res_valid, o_busy, o_timeout_err;
  logic [BIT_LENGTH-1:0] o_data_in, o_res_data;
  logic [IN_PORTS-1:0]   o_buffer_rd_in;
  logic [OUT_PORTS-1:0]  o_buffer_rd_out;
  logic [ADDR_LEN-1:0]   o_address_select;
  logic [SEL_LEN-1:0]    o_output_select, o_res_index;

  // Datapath stand-in: the mux returns a per-job random word for each port.
  assign mux_data = mux_vals[o_output_select];

  xbar_mult_sequencer #(
    .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS), .BIT_LENGTH(BIT_LENGTH), .ADDR_LEN(ADDR_LEN),
    .SEL_LEN(SEL_LEN), .LOAD_LEN(LOAD_LEN), .XBAR_LAT(XBAR_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_addr(cmd_addr),
    .i_load_valid(load_valid), .o_load_ready(o_load_ready), .i_load_data(load_data),
    .o_data_in(o_data_in), .o_buffer_rd_in(o_buffer_rd_in), .o_buffer_rd_out(o_buffer_rd_out),
    .o_buffer_select(o_buffer_select), .o_mstart_in(o_mstart_in), .o_mstart_out(o_mstart_out),
    .i_mready_in(mready_in), .i_mready_out(mready_out), .o_address_select(o_address_select),
    .o_output_select(o_output_select), .i_mux_data(mux_data),
    .o_res_valid(o_res_valid), .i_res_ready(res_ready), .o_res_data(o_res_data),
    .o_res_index(o_res_index), .o_busy(o_busy), .o_timeout_err(o_timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard of expected results, pushed by the job driver, popped by the monitor.
  logic [BIT_LENGTH-1:0] sb_data [$];
  int                    sb_idx  [$];

  logic [ADDR_LEN-1:0] exp_addr = '0;
  int rr_mode = 0;        // 0: always ready, 1: random, 2: stall 3 cycles on index 1
  int rd_in_low = 0, rd_out_cnt = 0, nstart_in = 0, nstart_out = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: per-cycle rules and scoreboard comparison, sampled on the falling edge.
  initial begin
    logic                  prev_hold;
    logic [BIT_LENGTH-1:0] prev_data;
    logic [SEL_LEN-1:0]    prev_idx;
    prev_hold = 1'b0; prev_data = '0; prev_idx = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        rd_in_low = 0; rd_out_cnt = 0; nstart_in = 0; nstart_out = 0;
      end else begin
        if (cmd_valid && o_cmd_ready) begin
          rd_in_low = 0; rd_out_cnt = 0; nstart_in = 0; nstart_out = 0;
        end
        chk("rd_in_rule", o_buffer_rd_in, (load_valid && o_load_ready) ? 64'h0 : 64'hF);
        if (load_valid && o_load_ready) rd_in_low++;
        if (o_buffer_rd_out != 4'hF) begin
          chk("rd_out_pattern", o_buffer_rd_out, 0);
          chk("route_bsel", o_buffer_select, rd_out_cnt >= LOAD_LEN);
          rd_out_cnt++;
        end
        if (o_mstart_in)  nstart_in++;
        if (o_mstart_out) nstart_out++;
        if (o_busy) chk("addr_const", o_address_select, exp_addr);
        if (prev_hold) begin
          chk("hold_valid", o_res_valid, 1);
          chk("hold_data", o_res_data, prev_data);
          chk("hold_index", o_res_index, prev_idx);
        end
        if (o_res_valid && res_ready) begin
          if (sb_data.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL res_unexpected: actual=result idx %0d data %0h required=no result",
                     o_res_index, o_res_data);
          end else begin
            chk("res_data", o_res_data, sb_data[0]);
            chk("res_index", o_res_index, sb_idx[0]);
            $display("result idx=%0d data=%08h", o_res_index, o_res_data);
            void'(sb_data.pop_front());
            void'(sb_idx.pop_front());
          end
        end
        prev_hold = o_res_valid && !res_ready;
        prev_data = o_res_data;
        prev_idx  = o_res_index;
      end
    end
  end

  // Result sink.
  initial begin
    int hold_cnt;
    hold_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!o_busy) hold_cnt = 0;
      case (rr_mode)
        1: res_ready = 1'($urandom_range(0, 1));
        2: if (o_res_valid && o_res_index == 2'd1 && hold_cnt < 3) begin
             res_ready = 1'b0; hold_cnt++;
           end else res_ready = 1'b1;
        default: res_ready = 1'b1;
      endcase
    end
  end

  // to_mode: 0 normal, 1 input bank never completes, 2 output bank never completes.
  task automatic run_job(input logic [ADDR_LEN-1:0] addr, input bit bp_load, input int rmode,
                         input int d_in, input int d_out, input int to_mode,
                         input bit busy_cmd, input bit abort);
    int k, n;
    bit found;
    rr_mode = rmode;
    for (int i = 0; i < OUT_PORTS; i++) mux_vals[i] = $urandom;
    found = 1'b0;
    for (n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (o_cmd_ready) begin found = 1'b1; break; end
    end
    chk("cmd_ready_seen", found, 1);
    if (!found) return;
    cmd_valid = 1'b1; cmd_addr = addr; exp_addr = addr;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("busy_after_cmd", o_busy, 1);
    chk("terr_cleared", o_timeout_err, 0);

    k = 0;
    for (n = 0; n < 200 && k < 2 * LOAD_LEN; n++) begin
      load_valid = bp_load ? ((n % 2) == 0) : 1'b1;
      load_data  = $urandom;
      @(negedge clk);
      if (load_valid && o_load_ready) begin
        chk("load_bsel", o_buffer_select, k >= LOAD_LEN);
        chk("data_in", o_data_in, load_data);
        k++;
      end
      @(posedge clk); #1;
      if (abort && k == 5) break;
    end
    load_valid = 1'b0;

    if (abort) begin
      @(posedge clk); #3;
      rst_n = 1'b0; #1;
      chk("rst_rd_in", o_buffer_rd_in, 4'hF);
      chk("rst_rd_out", o_buffer_rd_out, 4'hF);
      chk("rst_busy", o_busy, 0);
      chk("rst_cmd_ready", o_cmd_ready, 1);
      chk("rst_res_valid", o_res_valid, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_cmd_ready", o_cmd_ready, 1);
      chk("post_rst_busy", o_busy, 0);
      chk("post_rst_bsel", o_buffer_select, 0);
      $display("job addr=%02h aborted by reset after %0d words", addr, k);
      return;
    end
    chk("load_words", k, 2 * LOAD_LEN);

    found = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_mstart_in) begin found = 1'b1; break; end
    end
    chk("mstart_in_seen", found, 1);
    if (!found) return;
    chk("rd_in_low_cycles", rd_in_low, 2 * LOAD_LEN);

    if (to_mode == 1) begin
      mready_in = 4'b0111;
      found = 1'b0;
      for (n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (o_timeout_err) begin found = 1'b1; break; end
      end
      chk("timeout_in_cycles", n, 16);
      chk("timeout_in_idle", o_busy, 0);
      chk("timeout_in_no_route", rd_out_cnt, 0);
      chk("timeout_in_no_start_out", nstart_out, 0);
      chk("timeout_in_one_start", nstart_in, 1);
      mready_in = '0;
      $display("job addr=%02h input-bank timeout", addr);
      return;
    end

    repeat (d_in) @(posedge clk);
    #1 mready_in = '1;
    found = 1'b0;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (o_mstart_out) begin found = 1'b1; break; end
    end
    chk("mstart_out_seen", found, 1);
    if (!found) return;
    mready_in = '0;
    chk("rd_out_low_cycles", rd_out_cnt, 2 * LOAD_LEN);

    if (to_mode == 2) begin
      mready_out = 4'b1011;
      found = 1'b0;
      for (n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (o_timeout_err) begin found = 1'b1; break; end
      end
      chk("timeout_out_cycles", n, 16);
      chk("timeout_out_idle", o_busy, 0);
      chk("timeout_out_one_start", nstart_out, 1);
      mready_out = '0;
      $display("job addr=%02h output-bank timeout", addr);
      return;
    end

    if (busy_cmd) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_addr = ~exp_addr;
      repeat (3) begin
        @(negedge clk);
        chk("cmd_ready_while_busy", o_cmd_ready, 0);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end

    for (int i = 0; i < OUT_PORTS; i++) begin
      sb_data.push_back(mux_vals[i]);
      sb_idx.push_back(i);
    end
    repeat (d_out) @(posedge clk);
    #1 mready_out = '1;
    found = 1'b0;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!o_busy && sb_data.size() == 0) begin found = 1'b1; break; end
    end
    chk("drain_done", found, 1);
    chk("one_start_in", nstart_in, 1);
    chk("one_start_out", nstart_out, 1);
    chk("terr_clear_after_job", o_timeout_err, 0);
    mready_out = '0;
    if (!found) begin sb_data.delete(); sb_idx.delete(); end
    $display("job addr=%02h done, bp_load=%0d rmode=%0d busy_cmd=%0d", addr, bp_load, rmode, busy_cmd);
  endtask

  initial begin
    for (int i = 0; i < OUT_PORTS; i++) mux_vals[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rd_in", o_buffer_rd_in, 4'hF);
    chk("reset_rd_out", o_buffer_rd_out, 4'hF);
    chk("reset_busy", o_busy, 0);
    chk("reset_cmd_ready", o_cmd_ready, 1);
    chk("reset_terr", o_timeout_err, 0);
    chk("reset_res_valid", o_res_valid, 0);
    chk("reset_mstart", {o_mstart_in, o_mstart_out}, 0);
    chk("reset_addr", o_address_select, 0);

    run_job(8'h5A, 0, 0, 3, 3, 0, 0, 1);              // reset mid-load
    run_job(8'hE4, 0, 0, 5, 5, 0, 0, 0);              // full job
    run_job(8'($urandom), 1, 0, 4, 4, 0, 0, 0);       // load backpressure
    run_job(8'($urandom), 0, 2, 2, 3, 0, 0, 0);       // result backpressure on index 1
    run_job(8'($urandom), 0, 0, 0, 0, 1, 0, 0);       // input-bank timeout
    @(negedge clk);
    chk("terr_sticky", o_timeout_err, 1);
    run_job(8'($urandom), 0, 0, 3, 4, 0, 1, 0);       // busy command, clears timeout
    run_job(8'($urandom), 1, 1, 2, 2, 2, 0, 0);       // output-bank timeout
    for (int j = 0; j < 8; j++)
      run_job(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 8)), int'($urandom_range(0, 5)), 0,
              1'($urandom_range(0, 1)), 0);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
